// File: rtl/wishbone_master_engine.sv
// -----------------------------------------------------------------------------
// wishbone_master_engine
//
// Turns simple host commands into single or incrementing-burst Wishbone
// transactions. Each word has its own ack timeout. The slave interrupt line
// is edge-detected into a sticky pending flag.
//
// Ports
//   clk, rst             clock; asynchronous active-low reset
//   i_cmd_*/o_cmd_ready  command channel: we, start address, byte select, count
//   i_wr_*/o_wr_ready    write-data channel, one word per burst beat
//   o_rsp_*/i_rsp_ready  response channel: read data, 0 for a write, or the
//                        failing address with o_rsp_err on timeout
//   o_m_*/i_m_*          Wishbone master port
//   o_int_pending        sticky rising-edge flag of i_m_int
//   i_int_clear          clears o_int_pending (a simultaneous edge wins)
// -----------------------------------------------------------------------------
module wishbone_master_engine #(
   parameter logic [15:0] TIMEOUT = 16'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_cmd_valid,
   output logic        o_cmd_ready,
   input  logic        i_cmd_we,
   input  logic [31:0] i_cmd_adr,
   input  logic [3:0]  i_cmd_sel,
   input  logic [15:0] i_cmd_count,
   input  logic        i_wr_valid,
   output logic        o_wr_ready,
   input  logic [31:0] i_wr_dat,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [31:0] o_rsp_dat,
   output logic        o_rsp_err,
   output logic        o_m_we,
   output logic        o_m_stb,
   output logic        o_m_cyc,
   output logic [3:0]  o_m_sel,
   output logic [31:0] o_m_adr,
   output logic [31:0] o_m_dat,
   input  logic [31:0] i_m_dat,
   input  logic        i_m_ack,
   input  logic        i_m_int,
   output logic        o_int_pending,
   input  logic        i_int_clear
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_REQ,
      S_RSP,
      S_ERR
   } state_t;

   state_t      state_q, state_d;
   logic        we_q;
   logic [31:0] adr_q;
   logic [3:0]  sel_q;
   logic [15:0] cnt_q;       // words still to be acked
   logic [15:0] to_cnt_q;    // cycles spent in the current REQ
   logic [31:0] wdat_q;
   logic [31:0] rsp_dat_q;
   logic        cyc_q;
   logic        int_q, int_prev_q, pending_q;

   logic accept, fetch, acked, timeout;
   logic cmd_ready, wr_ready, stb, rsp_valid, rsp_err;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // NOTE: every signal written here gets a default first, so no path through
   // the case can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      wr_ready  = 1'b0;
      stb       = 1'b0;
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      accept    = 1'b0;
      fetch     = 1'b0;
      acked     = 1'b0;
      timeout   = 1'b0;
      case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (i_cmd_valid) begin
               accept  = 1'b1;
               state_d = i_cmd_we ? S_FETCH : S_REQ;
            end
         end
         S_FETCH: begin
            wr_ready = 1'b1;
            if (i_wr_valid) begin
               fetch   = 1'b1;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            stb = 1'b1;
            // An ack in the final allowed cycle still completes the word.
            if (i_m_ack) begin
               acked = 1'b1;
               if (!we_q || cnt_q == 16'd1) state_d = S_RSP;
               else                         state_d = S_FETCH;
            end else if (to_cnt_q == TIMEOUT - 16'd1) begin
               timeout = 1'b1;
               state_d = S_ERR;
            end
         end
         S_RSP: begin
            rsp_valid = 1'b1;
            if (i_rsp_ready) begin
               // cnt_q was already decremented by the ack that got us here.
               if (!we_q && cnt_q != 16'd0) state_d = S_REQ;
               else                         state_d = S_IDLE;
            end
         end
         S_ERR: begin
            rsp_valid = 1'b1;
            rsp_err   = 1'b1;
            if (i_rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_q      <= 1'b0;
         adr_q     <= '0;
         sel_q     <= '0;
         cnt_q     <= '0;
         to_cnt_q  <= '0;
         wdat_q    <= '0;
         rsp_dat_q <= '0;
         cyc_q     <= 1'b0;
      end else begin
         if (accept) begin
            we_q  <= i_cmd_we;
            adr_q <= i_cmd_adr;
            sel_q <= i_cmd_sel;
            cnt_q <= (i_cmd_count == 16'd0) ? 16'd1 : i_cmd_count;
         end
         if (fetch) wdat_q <= i_wr_dat;
         if (acked) begin
            adr_q     <= adr_q + 32'd4;   // wraps naturally at 2^32
            cnt_q     <= cnt_q - 16'd1;
            rsp_dat_q <= we_q ? 32'd0 : i_m_dat;
         end
         if (timeout) rsp_dat_q <= adr_q;

         // Restarts from 0 on every entry to REQ.
         if (state_q == S_REQ) to_cnt_q <= to_cnt_q + 16'd1;
         else                  to_cnt_q <= '0;

         // cyc spans the whole command, including FETCH gaps and RSP waits.
         if (state_d == S_IDLE || state_d == S_ERR) cyc_q <= 1'b0;
         else if (state_d == S_REQ)                 cyc_q <= 1'b1;
      end
   end

   // Two-stage sampling: edge is judged on registered values, so the flag
   // rises two cycles after i_m_int.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         int_q      <= 1'b0;
         int_prev_q <= 1'b0;
         pending_q  <= 1'b0;
      end else begin
         int_q      <= i_m_int;
         int_prev_q <= int_q;
         pending_q  <= (int_q & ~int_prev_q) | (pending_q & ~i_int_clear);
      end
   end

   assign o_cmd_ready   = cmd_ready;
   assign o_wr_ready    = wr_ready;
   assign o_rsp_valid   = rsp_valid;
   assign o_rsp_err     = rsp_err;
   assign o_rsp_dat     = rsp_valid ? rsp_dat_q : 32'd0;
   assign o_m_stb       = stb;
   assign o_m_cyc       = cyc_q;
   assign o_m_we        = cyc_q & we_q;
   assign o_m_adr       = adr_q;
   assign o_m_sel       = sel_q;
   assign o_m_dat       = wdat_q;
   assign o_int_pending = pending_q;

endmodule

// File: tb/tb_wishbone_master_engine.sv
// -----------------------------------------------------------------------------
// tb_wishbone_master_engine
//
// Directed bench for wishbone_master_engine with TIMEOUT = 8. Inputs are
// driven and outputs sampled on the falling edge; small posedge monitors count
// cyc-high cycles and response handshakes.
// -----------------------------------------------------------------------------
module tb_wishbone_master_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_cmd_valid = 1'b0;
   logic        o_cmd_ready;
   logic        i_cmd_we = 1'b0;
   logic [31:0] i_cmd_adr = '0;
   logic [3:0]  i_cmd_sel = '0;
   logic [15:0] i_cmd_count = '0;
   logic        i_wr_valid = 1'b0;
   logic        o_wr_ready;
   logic [31:0] i_wr_dat = '0;
   logic        o_rsp_valid;
   logic        i_rsp_ready = 1'b0;
   logic [31:0] o_rsp_dat;
   logic        o_rsp_err;
   logic        o_m_we, o_m_stb, o_m_cyc;
   logic [3:0]  o_m_sel;
   logic [31:0] o_m_adr, o_m_dat;
   logic [31:0] i_m_dat = '0;
   logic        i_m_ack = 1'b0;
   logic        i_m_int = 1'b0;
   logic        o_int_pending;
   logic        i_int_clear = 1'b0;

   int total = 0;
   int bad   = 0;
   int cyc_cnt = 0;
   int rsp_cnt = 0;

   always #5 clk = ~clk;

   wishbone_master_engine #(.TIMEOUT(16'd8)) dut (
      .clk(clk), .rst(rst),
      .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_we(i_cmd_we),
      .i_cmd_adr(i_cmd_adr), .i_cmd_sel(i_cmd_sel), .i_cmd_count(i_cmd_count),
      .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_dat(i_wr_dat),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_dat(o_rsp_dat),
      .o_rsp_err(o_rsp_err), .o_m_we(o_m_we), .o_m_stb(o_m_stb), .o_m_cyc(o_m_cyc),
      .o_m_sel(o_m_sel), .o_m_adr(o_m_adr), .o_m_dat(o_m_dat), .i_m_dat(i_m_dat),
      .i_m_ack(i_m_ack), .i_m_int(i_m_int), .o_int_pending(o_int_pending),
      .i_int_clear(i_int_clear)
   );

   always @(posedge clk) begin
      if (o_m_cyc) cyc_cnt++;
      if (o_rsp_valid && i_rsp_ready) rsp_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic issue(input logic we, input logic [31:0] adr, input logic [15:0] cnt);
      i_cmd_valid = 1'b1;
      i_cmd_we    = we;
      i_cmd_adr   = adr;
      i_cmd_sel   = 4'hF;
      i_cmd_count = cnt;
      tick();
      i_cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      total++; if (o_cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=1", o_cmd_ready); end
      total++; if ({o_m_cyc, o_m_stb, o_m_we, o_wr_ready, o_rsp_valid, o_rsp_err, o_int_pending} !== 7'b0) begin
         bad++; $display("FAIL rst_ctrl got=%b exp=0000000", {o_m_cyc, o_m_stb, o_m_we, o_wr_ready, o_rsp_valid, o_rsp_err, o_int_pending}); end
      total++; if ({o_m_adr, o_m_dat, o_rsp_dat, o_m_sel} !== 100'b0) begin
         bad++; $display("FAIL rst_data adr=%h dat=%h rsp=%h sel=%h exp all 0", o_m_adr, o_m_dat, o_rsp_dat, o_m_sel); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_single_read();
      cyc_cnt = 0; rsp_cnt = 0; i_rsp_ready = 1'b1;
      issue(1'b0, 32'h0100_0010, 16'd0);
      total++; if ({o_m_cyc, o_m_stb, o_m_we} !== 3'b110) begin bad++; $display("FAIL rd_ctrl got=%b exp=110", {o_m_cyc, o_m_stb, o_m_we}); end
      total++; if (o_m_adr !== 32'h0100_0010 || o_m_sel !== 4'hF) begin bad++; $display("FAIL rd_adr got=%h/%h exp=01000010/f", o_m_adr, o_m_sel); end
      tick();
      i_m_ack = 1'b1; i_m_dat = 32'hDEAD_BEEF;
      tick();
      i_m_ack = 1'b0; i_m_dat = 32'h0;
      total++; if (o_rsp_valid !== 1'b1 || o_m_stb !== 1'b0 || o_rsp_err !== 1'b0) begin
         bad++; $display("FAIL rd_rsp valid/stb/err got=%b%b%b exp=100", o_rsp_valid, o_m_stb, o_rsp_err); end
      total++; if (o_rsp_dat !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_dat got=%h exp=deadbeef", o_rsp_dat); end
      tick();
      total++; if (o_cmd_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_idle got ready=%b valid=%b exp 1/0", o_cmd_ready, o_rsp_valid); end
      total++; if (cyc_cnt !== 3) begin bad++; $display("FAIL rd_cyc_len got=%0d exp=3", cyc_cnt); end
      total++; if (rsp_cnt !== 1) begin bad++; $display("FAIL rd_rsp_cnt got=%0d exp=1", rsp_cnt); end
      i_rsp_ready = 1'b0;
   endtask

   task automatic test_burst_write();
      rsp_cnt = 0; i_rsp_ready = 1'b1;
      issue(1'b1, 32'h0200_0000, 16'd3);
      total++; if ({o_wr_ready, o_m_stb, o_m_cyc} !== 3'b100) begin bad++; $display("FAIL wr_fetch0 got=%b exp=100", {o_wr_ready, o_m_stb, o_m_cyc}); end
      i_wr_valid = 1'b1; i_wr_dat = 32'h11;
      tick();
      i_wr_valid = 1'b0;
      total++; if ({o_m_cyc, o_m_stb, o_m_we} !== 3'b111 || o_m_adr !== 32'h0200_0000 || o_m_dat !== 32'h11) begin
         bad++; $display("FAIL wr_w0 ctrl=%b adr=%h dat=%h exp=111/02000000/11", {o_m_cyc, o_m_stb, o_m_we}, o_m_adr, o_m_dat); end
      i_m_ack = 1'b1;
      tick();
      i_m_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         total++; if ({o_m_cyc, o_m_stb, o_wr_ready, o_rsp_valid} !== 4'b1010) begin
            bad++; $display("FAIL wr_stall%0d cyc/stb/wr_ready/rsp got=%b exp=1010", i, {o_m_cyc, o_m_stb, o_wr_ready, o_rsp_valid}); end
         tick();
      end
      i_wr_valid = 1'b1; i_wr_dat = 32'h22;
      tick();
      i_wr_valid = 1'b0;
      total++; if (o_m_stb !== 1'b1 || o_m_adr !== 32'h0200_0004 || o_m_dat !== 32'h22) begin
         bad++; $display("FAIL wr_w1 stb=%b adr=%h dat=%h exp=1/02000004/22", o_m_stb, o_m_adr, o_m_dat); end
      i_m_ack = 1'b1;
      tick();
      i_m_ack = 1'b0; i_wr_valid = 1'b1; i_wr_dat = 32'h33;
      tick();
      i_wr_valid = 1'b0;
      total++; if (o_m_stb !== 1'b1 || o_m_adr !== 32'h0200_0008 || o_m_dat !== 32'h33) begin
         bad++; $display("FAIL wr_w2 stb=%b adr=%h dat=%h exp=1/02000008/33", o_m_stb, o_m_adr, o_m_dat); end
      i_m_ack = 1'b1;
      tick();
      i_m_ack = 1'b0;
      total++; if ({o_rsp_valid, o_rsp_err, o_m_stb, o_m_cyc} !== 4'b1001 || o_rsp_dat !== 32'h0) begin
         bad++; $display("FAIL wr_rsp valid/err/stb/cyc=%b dat=%h exp=1001/0", {o_rsp_valid, o_rsp_err, o_m_stb, o_m_cyc}, o_rsp_dat); end
      tick();
      total++; if (o_m_cyc !== 1'b0 || o_cmd_ready !== 1'b1 || rsp_cnt !== 1) begin
         bad++; $display("FAIL wr_end cyc=%b ready=%b rsps=%0d exp=0/1/1", o_m_cyc, o_cmd_ready, rsp_cnt); end
      i_rsp_ready = 1'b0;
   endtask

   task automatic test_read_backpressure();
      rsp_cnt = 0; i_rsp_ready = 1'b0;
      issue(1'b0, 32'h0300_0100, 16'd2);
      i_m_ack = 1'b1; i_m_dat = 32'hA5A5_0001;
      tick();
      i_m_ack = 1'b0; i_m_dat = 32'hFFFF_0000;
      for (int i = 0; i < 5; i++) begin
         total++; if (o_rsp_valid !== 1'b1 || o_m_stb !== 1'b0 || o_rsp_dat !== 32'hA5A5_0001) begin
            bad++; $display("FAIL bp_stall%0d valid=%b stb=%b dat=%h exp=1/0/a5a50001", i, o_rsp_valid, o_m_stb, o_rsp_dat); end
         tick();
      end
      i_rsp_ready = 1'b1;
      tick();
      i_rsp_ready = 1'b0;
      total++; if (o_m_stb !== 1'b1 || o_rsp_valid !== 1'b0 || o_m_adr !== 32'h0300_0104) begin
         bad++; $display("FAIL bp_req2 stb=%b valid=%b adr=%h exp=1/0/03000104", o_m_stb, o_rsp_valid, o_m_adr); end
      i_m_ack = 1'b1; i_m_dat = 32'hA5A5_0002;
      tick();
      i_m_ack = 1'b0;
      total++; if (o_rsp_dat !== 32'hA5A5_0002) begin bad++; $display("FAIL bp_dat2 got=%h exp=a5a50002", o_rsp_dat); end
      i_rsp_ready = 1'b1;
      tick();
      i_rsp_ready = 1'b0;
      total++; if (o_cmd_ready !== 1'b1 || rsp_cnt !== 2) begin bad++; $display("FAIL bp_end ready=%b rsps=%0d exp=1/2", o_cmd_ready, rsp_cnt); end
   endtask

   task automatic test_timeout();
      int req_cycles = 0;
      bit seen = 1'b0;
      i_rsp_ready = 1'b0;
      issue(1'b0, 32'h7F00_0000, 16'd4);
      for (int i = 0; i < 20 && !seen; i++) begin
         if (o_rsp_valid) seen = 1'b1;
         else begin
            if (o_m_stb) req_cycles++;
            tick();
         end
      end
      total++; if (!seen) begin bad++; $display("FAIL to_no_err got=no response within 20 cycles exp=response"); end
      total++; if (req_cycles !== 8) begin bad++; $display("FAIL to_req_cycles got=%0d exp=8", req_cycles); end
      total++; if ({o_rsp_err, o_m_cyc, o_m_stb, o_wr_ready} !== 4'b1000 || o_rsp_dat !== 32'h7F00_0000) begin
         bad++; $display("FAIL to_err err/cyc/stb/wr=%b dat=%h exp=1000/7f000000", {o_rsp_err, o_m_cyc, o_m_stb, o_wr_ready}, o_rsp_dat); end
      i_rsp_ready = 1'b1;
      tick();
      i_rsp_ready = 1'b0;
      total++; if ({o_cmd_ready, o_rsp_valid, o_rsp_err, o_m_cyc} !== 4'b1000) begin
         bad++; $display("FAIL to_idle ready/valid/err/cyc=%b exp=1000", {o_cmd_ready, o_rsp_valid, o_rsp_err, o_m_cyc}); end
   endtask

   task automatic test_ack_at_deadline();
      issue(1'b0, 32'h0400_0000, 16'd1);
      for (int i = 0; i < 7; i++) tick();
      i_m_ack = 1'b1; i_m_dat = 32'h1234_5678;
      tick();
      i_m_ack = 1'b0;
      total++; if (o_rsp_valid !== 1'b1 || o_rsp_err !== 1'b0 || o_rsp_dat !== 32'h1234_5678) begin
         bad++; $display("FAIL deadline valid=%b err=%b dat=%h exp=1/0/12345678", o_rsp_valid, o_rsp_err, o_rsp_dat); end
      i_rsp_ready = 1'b1;
      tick();
      i_rsp_ready = 1'b0;
   endtask

   task automatic test_addr_wrap();
      i_rsp_ready = 1'b1;
      issue(1'b0, 32'hFFFF_FFFC, 16'd2);
      total++; if (o_m_adr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_adr0 got=%h exp=fffffffc", o_m_adr); end
      i_m_ack = 1'b1; i_m_dat = 32'h1;
      tick();
      i_m_ack = 1'b0;
      tick();
      total++; if (o_m_stb !== 1'b1 || o_m_adr !== 32'h0000_0000) begin bad++; $display("FAIL wrap_adr1 stb=%b adr=%h exp=1/00000000", o_m_stb, o_m_adr); end
      i_m_ack = 1'b1; i_m_dat = 32'h2;
      tick();
      i_m_ack = 1'b0;
      total++; if (o_rsp_dat !== 32'h2) begin bad++; $display("FAIL wrap_dat1 got=%h exp=00000002", o_rsp_dat); end
      tick();
      i_rsp_ready = 1'b0;
   endtask

   task automatic test_interrupt();
      i_m_int = 1'b1;
      tick();
      i_m_int = 1'b0;
      total++; if (o_int_pending !== 1'b0) begin bad++; $display("FAIL int_early got=%b exp=0", o_int_pending); end
      tick();
      total++; if (o_int_pending !== 1'b1) begin bad++; $display("FAIL int_set got=%b exp=1", o_int_pending); end
      tick();
      i_m_int = 1'b1;
      tick();
      i_int_clear = 1'b1;
      tick();
      i_int_clear = 1'b0;
      total++; if (o_int_pending !== 1'b1) begin bad++; $display("FAIL int_set_wins got=%b exp=1", o_int_pending); end
      i_int_clear = 1'b1;
      tick();
      i_int_clear = 1'b0;
      total++; if (o_int_pending !== 1'b0) begin bad++; $display("FAIL int_clear got=%b exp=0", o_int_pending); end
      tick();
      total++; if (o_int_pending !== 1'b0) begin bad++; $display("FAIL int_held got=%b exp=0", o_int_pending); end
      i_m_int = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_req();
      issue(1'b0, 32'h0500_0000, 16'd2);
      total++; if (o_m_stb !== 1'b1 || o_m_cyc !== 1'b1) begin bad++; $display("FAIL mid_pre stb=%b cyc=%b exp=1/1", o_m_stb, o_m_cyc); end
      #2 rst = 1'b0;
      #1;
      total++; if ({o_m_cyc, o_m_stb, o_rsp_valid, o_cmd_ready} !== 4'b0001 || o_m_adr !== 32'h0 || o_m_sel !== 4'h0) begin
         bad++; $display("FAIL mid_rst cyc/stb/valid/ready=%b adr=%h sel=%h exp=0001/0/0", {o_m_cyc, o_m_stb, o_rsp_valid, o_cmd_ready}, o_m_adr, o_m_sel); end
      @(negedge clk);
      rst = 1'b1;
      tick();
      tick();
      total++; if (o_cmd_ready !== 1'b1 || o_m_cyc !== 1'b0 || o_rsp_valid !== 1'b0) begin
         bad++; $display("FAIL mid_after ready=%b cyc=%b valid=%b exp=1/0/0", o_cmd_ready, o_m_cyc, o_rsp_valid); end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_burst_write();
      test_read_backpressure();
      test_timeout();
      test_ack_at_deadline();
      test_addr_wrap();
      test_interrupt();
      test_reset_mid_req();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
